decodificador_varredura: RTL and testbench
==========================================

# decodificador_varredura

Parametrised N-to-2^N one-hot decoder with enable, registered outputs and an automatic scan mode. It drives the select lines of multiplexed peripherals such as digit commons for multiplexed 7-segment displays, LED columns and chip selects. In direct mode it decodes an external select. In scan mode it walks every output in turn with a programmable dwell time.

## Interface
- `N`, 3: select width; output count is 2^N (N from 1 to 6).
- `DWELL`, 4: clock cycles each output stays active in scan mode (DWELL ≥ 1).
- `ATIVO_BAIXO`, 0: 1 = outputs active-low (inactive = 1), 0 = active-high.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: enable; 0 forces all outputs inactive and freezes scan state.
- `modo`, in, 1: 0 = direct decode of `sel`, 1 = automatic scan.
- `sel`, in, N: direct-mode select; scan-mode start index when `carrega` = 1.
- `carrega`, in, 1: scan mode only; loads `sel` into the scan index.
- `y`, out, 2^N: one-hot decoded outputs (polarity per `ATIVO_BAIXO`).
- `idx`, out, N: index of the currently active output.
- `volta`, out, 1: one-cycle pulse when the scan wraps from 2^N−1 to 0.

## Operation
- Bit mapping: `y[i]` is active exactly when the decoded index equals i. `sel[N-1]` is the MSB.
- Internal registers: `idx` (N bits), dwell counter `cnt` (width clog2(DWELL), minimum 1), `y`, `volta`.
- Reset values (asynchronous, `rst` = 1):
  - `idx` = 0, `cnt` = 0, `volta` = 0.
  - `y` = all inactive: all 0, or all 1 when `ATIVO_BAIXO` = 1.
- Effective states, evaluated each cycle:
  - DESLIGADO (`en` = 0):
    - `idx` and `cnt` hold; `y` goes inactive; `volta` = 0.
    - `carrega` and `sel` are ignored.
  - DIRETO (`en` = 1, `modo` = 0):
    - `idx` ← `sel`, `cnt` ← 0, `volta` = 0.
    - `y` ← onehot(`sel`).
  - VARREDURA (`en` = 1, `modo` = 1), in priority order:
    - `carrega` = 1: `idx` ← `sel`, `cnt` ← 0, `volta` = 0.
    - else if `cnt` = DWELL−1: `cnt` ← 0 and `idx` ← `idx`+1 modulo 2^N. `volta` ← 1 iff the old `idx` = 2^N−1.
    - else: `cnt` ← `cnt`+1, `idx` holds, `volta` = 0.
    - `y` ← onehot(next `idx`).
- Invariant: while `en` = 1, `y` always equals onehot(`idx`) in the same cycle. Exactly one output is active; never zero and never two.
- Mode transitions:
  - DIRETO→VARREDURA: the scan continues from the last `sel` with `cnt` = 0. The first output stays active for a full DWELL cycles.
  - VARREDURA→DIRETO: the scan position is discarded and `sel` takes over on the next edge.
- Re-enable (`en` 0→1) in VARREDURA resumes at the frozen `idx`/`cnt`. The first active cycle shows onehot of the next `idx`, computed from the frozen `cnt`.
- DWELL = 1: `idx` advances every enabled cycle.
- `rst` mid-scan: immediate return to reset values, independent of `clk`. Operation resumes on the first edge after `rst` falls.

## Timing
- Latency:
  - Direct mode: `sel` sampled at edge k appears on `y`/`idx` after edge k (1 cycle).
  - `en` falling: `y` goes inactive after the next edge (1 cycle).
- Scan period: each index is active DWELL cycles; a full sweep is DWELL·2^N cycles.
- `volta` is registered and high for exactly one cycle, coincident with `idx` = 0 following 2^N−1. It is not asserted on `carrega` to 0 or on a direct `sel` of 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert `rst` mid-scan with `clk` stopped -> `y` = 0x00, `idx` = 0, `volta` = 0 immediately. With `ATIVO_BAIXO` = 1 -> `y` = 0xFF.
- Direct decode (N = 3): `en` = 1, `modo` = 0, sweep `sel` 0..7 -> one cycle later `y` = 0x01, 0x02, …, 0x80. Then `en` = 0 -> `y` = 0x00 after the next edge.
- Scan (DWELL = 4): `modo` = 1 from `idx` 0 -> `y` holds each of 0x01…0x80 for 4 cycles. After 0x80 the next value is 0x01 with `volta` = 1 for exactly 1 cycle. The sweep is 32 cycles long.
- Load: in scan at `idx` = 2, `cnt` = 1, pulse `carrega` with `sel` = 6 -> next cycle `idx` = 6, `y` = 0x40 for 4 cycles. `volta` rises when `idx` goes 7→0.
- Freeze/resume: in scan at `idx` = 5, `cnt` = 2, drop `en` for 3 cycles -> `y` = 0x00 during the gap. On resume, `y` = 0x20 for 1 more cycle, then 0x40.
- Edge parameters: N = 1, DWELL = 1 -> `y` alternates 0b01/0b10 every cycle and `volta` pulses every 2 cycles. N = 6 -> 64 distinct one-hot values.

Source files
------------

// File: rtl/decodificador_varredura.sv
// One-hot decoder with enable, registered outputs and a timed scan mode.
// Drives digit commons, LED columns or chip selects of multiplexed peripherals.
module decodificador_varredura #(
  parameter int N           = 3,
  parameter int DWELL       = 4,
  parameter bit ATIVO_BAIXO = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               modo,
  input  logic [N-1:0]       sel,
  input  logic               carrega,
  output logic [(1<<N)-1:0]  y,
  output logic [N-1:0]       idx,
  output logic               volta
);

  localparam int M  = 1 << N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [M-1:0] INATIVO = ATIVO_BAIXO ? {M{1'b1}} : {M{1'b0}};

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [N-1:0]  idx_n;
  logic          volta_n;
  logic [M-1:0]  oh_n;

  // Next index is decoded here so y always matches idx in the same cycle.
  always_comb begin
    idx_n   = idx;
    cnt_n   = cnt;
    volta_n = 1'b0;
    priority case (1'b1)
      !en: ;
      !modo: begin
        idx_n = sel;
        cnt_n = '0;
      end
      carrega: begin
        idx_n = sel;
        cnt_n = '0;
      end
      (cnt == LAST): begin
        cnt_n   = '0;
        idx_n   = idx + N'(1);
        volta_n = (idx == {N{1'b1}});
      end
      default: cnt_n = cnt + CW'(1);
    endcase
    oh_n = M'(1) << idx_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      cnt   <= '0;
      volta <= 1'b0;
      y     <= INATIVO;
    end else begin
      idx   <= idx_n;
      cnt   <= cnt_n;
      volta <= volta_n;
      y     <= en ? (oh_n ^ INATIVO) : INATIVO;
    end
  end

endmodule

// File: tb/tb_decodificador_varredura.sv
// Bench for decodificador_varredura: direct table, scan sequences,
// randomized traffic against a reference model, and edge parameter sets.
module tb_decodificador_varredura;

  localparam int N  = 3;
  localparam int M  = 8;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, modo = 1'b0, carrega = 1'b0;
  logic [N-1:0] sel = '0;
  logic [M-1:0] y;
  logic [N-1:0] idx;
  logic volta;

  logic en2 = 1'b0;
  logic modo2 = 1'b1;
  logic carrega2 = 1'b0;
  logic [0:0] sel2 = '0;
  logic [1:0] y2;
  logic [0:0] idx2;
  logic volta2;
  logic [5:0] sel3 = '0;
  logic [63:0] y3;
  logic [5:0] idx3;
  logic volta3;

  int vecs = 0;
  int errs = 0;

  int mi = 0, mc = 0;
  logic [M-1:0] my = '0;
  logic mv = 1'b0;

  always #5 clk = ~clk;

  decodificador_varredura #(.N(N), .DWELL(DW), .ATIVO_BAIXO(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .modo(modo), .sel(sel),
    .carrega(carrega), .y(y), .idx(idx), .volta(volta)
  );

  decodificador_varredura #(.N(1), .DWELL(1), .ATIVO_BAIXO(1'b1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .modo(modo2), .sel(sel2),
    .carrega(carrega2), .y(y2), .idx(idx2), .volta(volta2)
  );

  decodificador_varredura #(.N(6), .DWELL(1), .ATIVO_BAIXO(1'b0)) dut3 (
    .clk(clk), .rst(rst), .en(en2), .modo(modo2), .sel(sel3),
    .carrega(carrega2), .y(y3), .idx(idx3), .volta(volta3)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the scan as integer index/dwell arithmetic modulo 2^N.
  task automatic model_step();
    mv = 1'b0;
    if (en) begin
      if (!modo || carrega) begin
        mi = int'(sel);
        mc = 0;
      end else if (mc == DW - 1) begin
        mv = (mi == M - 1);
        mi = (mi + 1) % M;
        mc = 0;
      end else begin
        mc = mc + 1;
      end
      my = M'(1) << mi;
    end else begin
      my = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_y", 64'(y), 64'(my));
    chk("model_idx", 64'(idx), 64'(mi));
    chk("model_volta", 64'(volta), 64'(mv));
  endtask

  typedef struct {
    logic en;
    logic modo;
    logic carrega;
    logic [N-1:0] sel;
    logic [M-1:0] y;
    logic [N-1:0] idx;
    logic volta;
  } vec_t;

  vec_t tbl[9];

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i].en = 1'b1;
      tbl[i].modo = 1'b0;
      tbl[i].carrega = 1'b0;
      tbl[i].sel = N'(i);
      tbl[i].y = M'(1) << i;
      tbl[i].idx = N'(i);
      tbl[i].volta = 1'b0;
    end
    tbl[8].en = 1'b0;
    tbl[8].modo = 1'b0;
    tbl[8].carrega = 1'b0;
    tbl[8].sel = 3'd2;
    tbl[8].y = 8'h00;
    tbl[8].idx = 3'd7;
    tbl[8].volta = 1'b0;

    // reset state
    #12;
    chk("rst_y", 64'(y), 64'h0);
    chk("rst_idx", 64'(idx), 64'h0);
    chk("rst_volta", 64'(volta), 64'h0);
    chk("rst_y_low", 64'(y2), 64'h3);
    rst = 1'b0;
    tick();

    // direct decode table
    foreach (tbl[i]) begin
      en = tbl[i].en;
      modo = tbl[i].modo;
      carrega = tbl[i].carrega;
      sel = tbl[i].sel;
      tick();
      chk("tbl_y", 64'(y), 64'(tbl[i].y));
      chk("tbl_idx", 64'(idx), 64'(tbl[i].idx));
      chk("tbl_volta", 64'(volta), 64'(tbl[i].volta));
    end

    // full scan from index 0
    en = 1'b1; modo = 1'b0; sel = 3'd0;
    tick();
    modo = 1'b1;
    for (int t = 1; t <= 64; t++) begin
      sel = N'($urandom);
      tick();
      chk("sweep_y", 64'(y), 64'(M'(1) << ((t / 4) % 8)));
      chk("sweep_volta", 64'(volta), 64'(t % 32 == 0));
    end

    // load mid-dwell at idx 2, cnt 1
    modo = 1'b0; sel = 3'd2;
    tick();
    modo = 1'b1;
    tick();
    chk("pre_load_idx", 64'(idx), 64'd2);
    carrega = 1'b1; sel = 3'd6;
    tick();
    chk("load_idx", 64'(idx), 64'd6);
    chk("load_y", 64'(y), 64'h40);
    chk("load_volta", 64'(volta), 64'd0);
    carrega = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      sel = N'($urandom);
      tick();
      chk("load_seq_idx", 64'(idx), 64'((6 + t / 4) % 8));
      chk("load_seq_volta", 64'(volta), 64'(t == 8));
    end

    // freeze at idx 5, cnt 2 and resume
    modo = 1'b0; sel = 3'd5;
    tick();
    modo = 1'b1;
    tick();
    tick();
    en = 1'b0;
    for (int t = 0; t < 3; t++) begin
      carrega = t[0];
      sel = N'($urandom);
      tick();
      chk("gap_y", 64'(y), 64'h0);
      chk("gap_idx", 64'(idx), 64'd5);
    end
    carrega = 1'b0;
    en = 1'b1;
    tick();
    chk("resume_y0", 64'(y), 64'h20);
    tick();
    chk("resume_y1", 64'(y), 64'h40);

    // randomized traffic
    for (int t = 0; t < 2000; t++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) modo = ~modo;
      carrega = ($urandom_range(0, 19) == 0);
      sel = N'($urandom);
      tick();
      if (en) chk("rand_onehot", 64'($countones(y)), 64'd1);
    end

    // asynchronous reset between edges
    en = 1'b1; modo = 1'b1; carrega = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    mi = 0; mc = 0; my = '0; mv = 1'b0;
    chk("arst_y", 64'(y), 64'h0);
    chk("arst_idx", 64'(idx), 64'h0);
    chk("arst_volta", 64'(volta), 64'h0);
    chk("arst_y_low", 64'(y2), 64'h3);
    @(posedge clk);
    #1;
    chk("arst_hold_idx", 64'(idx), 64'h0);
    #2 rst = 1'b0;
    en = 1'b0;
    tick();

    // N=1 / N=6 with DWELL=1
    en2 = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk("n1_y", 64'(y2), 64'(~(2'b01 << (k % 2)) & 2'b11));
      chk("n1_volta", 64'(volta2), 64'(k % 2 == 0));
      chk("n6_y", y3, 64'd1 << (k % 64));
      chk("n6_volta", 64'(volta3), 64'(k == 64));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
